// File: rtl/cdb_broadcast_unit.sv
// rtl/cdb_broadcast_unit.sv - Dual-slot CDB producer fed by three result sources through an in-order queue
module cdb_broadcast_unit #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     src0_valid,
    input  logic [3:0]               src0_tag,
    input  logic [15:0]              src0_data,
    output logic                     src0_ready,
    input  logic                     src1_valid,
    input  logic [3:0]               src1_tag,
    input  logic [15:0]              src1_data,
    output logic                     src1_ready,
    input  logic                     src2_valid,
    input  logic [3:0]               src2_tag,
    input  logic [15:0]              src2_data,
    output logic                     src2_ready,
    output logic [41:0]              CDBData,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [19:0]   mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [41:0]   cdb_q, cdb_d;

    logic [CW-1:0] k_w;
    logic [CW-1:0] free_w;
    logic [CW-1:0] before1_w;
    logic [CW-1:0] before2_w;
    logic [CW-1:0] n_acc_w;
    logic          acc0_w, acc1_w, acc2_w;
    logic          en_w;
    logic [PW-1:0] idx1_w, idx2_w;
    logic [PW-1:0] head_p1_w;

    always_comb begin
        k_w       = (count_q >= CW'(2)) ? CW'(2) : count_q;
        free_w    = CW'(DEPTH) - count_q + k_w;
        before1_w = CW'(src0_valid);
        before2_w = CW'(src0_valid) + CW'(src1_valid);
        en_w      = rst_n & ~flush;

        // Readies depend only on count and lower-index valids, never on their own valid.
        src0_ready = en_w && (CW'(0) < free_w);
        src1_ready = en_w && (before1_w < free_w);
        src2_ready = en_w && (before2_w < free_w);

        acc0_w  = src0_valid & src0_ready;
        acc1_w  = src1_valid & src1_ready;
        acc2_w  = src2_valid & src2_ready;
        n_acc_w = CW'(acc0_w) + CW'(acc1_w) + CW'(acc2_w);

        idx1_w    = tail_q + PW'(acc0_w);
        idx2_w    = idx1_w + PW'(acc1_w);
        tail_d    = tail_q + PW'(n_acc_w);
        head_d    = head_q + PW'(k_w);
        head_p1_w = head_q + PW'(1);
        count_d   = count_q - k_w + n_acc_w;

        cdb_d = '0;
        if (k_w >= CW'(1)) begin
            cdb_d[20:0] = {1'b1, mem_q[head_q]};
        end
        if (k_w == CW'(2)) begin
            cdb_d[41:21] = {1'b1, mem_q[head_p1_w]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            cdb_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            cdb_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            cdb_q   <= cdb_d;
            // Drained slots are read from the old contents, so same-edge reuse is safe.
            if (acc0_w) mem_q[tail_q] <= {src0_tag, src0_data};
            if (acc1_w) mem_q[idx1_w] <= {src1_tag, src1_data};
            if (acc2_w) mem_q[idx2_w] <= {src2_tag, src2_data};
        end
    end

    assign CDBData   = cdb_q;
    assign occupancy = count_q;

endmodule

// File: tb/tb_cdb_broadcast_unit.sv
// tb/tb_cdb_broadcast_unit.sv - Directed self-checking bench for cdb_broadcast_unit
module tb_cdb_broadcast_unit;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        src0_valid, src1_valid, src2_valid;
    logic [3:0]  src0_tag, src1_tag, src2_tag;
    logic [15:0] src0_data, src1_data, src2_data;
    logic        src0_ready, src1_ready, src2_ready;
    logic [41:0] CDBData;
    logic [2:0]  occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    cdb_broadcast_unit #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .src0_valid (src0_valid),
        .src0_tag   (src0_tag),
        .src0_data  (src0_data),
        .src0_ready (src0_ready),
        .src1_valid (src1_valid),
        .src1_tag   (src1_tag),
        .src1_data  (src1_data),
        .src1_ready (src1_ready),
        .src2_valid (src2_valid),
        .src2_tag   (src2_tag),
        .src2_data  (src2_data),
        .src2_ready (src2_ready),
        .CDBData    (CDBData),
        .occupancy  (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [41:0] bus(input logic vu, input logic [3:0] tu, input logic [15:0] du,
                                        input logic vl, input logic [3:0] tl, input logic [15:0] dl);
        return {vu, tu, du, vl, tl, dl};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_srcs();
        src0_valid = 0; src1_valid = 0; src2_valid = 0;
    endtask

    task automatic set_all(input logic [3:0] t0, input logic [15:0] d0,
                           input logic [3:0] t1, input logic [15:0] d1,
                           input logic [3:0] t2, input logic [15:0] d2);
        src0_valid = 1; src0_tag = t0; src0_data = d0;
        src1_valid = 1; src1_tag = t1; src1_data = d1;
        src2_valid = 1; src2_tag = t2; src2_data = d2;
    endtask

    initial begin
        rst_n = 0; flush = 0;
        idle_srcs();
        src0_tag = 0; src1_tag = 0; src2_tag = 0;
        src0_data = 0; src1_data = 0; src2_data = 0;
        #12;
        check("rst_cdb", 64'(CDBData), 64'd0);
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_rdy", 64'({src0_ready, src1_ready, src2_ready}), 64'b000);
        rst_n = 1;
        #1;
        check("post_rst_rdy", 64'({src0_ready, src1_ready, src2_ready}), 64'b111);
        tick();

        // Single result from src1
        src1_valid = 1; src1_tag = 4'd5; src1_data = 16'h1234;
        #1;
        check("single_rdy", 64'(src1_ready), 64'd1);
        tick();
        check("single_occ", 64'(occupancy), 64'd1);
        check("single_cdb0", 64'(CDBData), 64'd0);
        idle_srcs();
        tick();
        check("single_cdb1", 64'(CDBData), 64'(bus(0, 0, 0, 1, 4'd5, 16'h1234)));
        check("single_occ1", 64'(occupancy), 64'd0);
        tick();
        check("single_cdb2", 64'(CDBData), 64'd0);

        // Three simultaneous results
        set_all(4'd1, 16'hAAAA, 4'd2, 16'hBBBB, 4'd3, 16'hCCCC);
        #1;
        check("three_rdy", 64'({src0_ready, src1_ready, src2_ready}), 64'b111);
        tick();
        check("three_occ", 64'(occupancy), 64'd3);
        idle_srcs();
        tick();
        check("three_cdb1", 64'(CDBData), 64'(bus(1, 4'd2, 16'hBBBB, 1, 4'd1, 16'hAAAA)));
        tick();
        check("three_cdb2", 64'(CDBData), 64'(bus(0, 0, 0, 1, 4'd3, 16'hCCCC)));
        check("three_occ2", 64'(occupancy), 64'd0);
        tick();
        check("three_cdb3", 64'(CDBData), 64'd0);

        // Backpressure with all sources held valid
        set_all(4'd1, 16'h0011, 4'd2, 16'h0022, 4'd3, 16'h0033);
        #1;
        check("bp_rdy_e1", 64'({src0_ready, src1_ready, src2_ready}), 64'b111);
        tick();
        check("bp_occ_e1", 64'(occupancy), 64'd3);
        #1;
        check("bp_rdy_e2", 64'({src0_ready, src1_ready, src2_ready}), 64'b111);
        tick();
        check("bp_occ_e2", 64'(occupancy), 64'd4);
        check("bp_cdb_e2", 64'(CDBData), 64'(bus(1, 4'd2, 16'h0022, 1, 4'd1, 16'h0011)));
        #1;
        check("bp_rdy_e3", 64'({src0_ready, src1_ready, src2_ready}), 64'b110);
        tick();
        check("bp_occ_e3", 64'(occupancy), 64'd4);
        check("bp_cdb_e3", 64'(CDBData), 64'(bus(1, 4'd1, 16'h0011, 1, 4'd3, 16'h0033)));
        #1;
        check("bp_rdy_e4", 64'({src0_ready, src1_ready, src2_ready}), 64'b110);
        tick();
        check("bp_occ_e4", 64'(occupancy), 64'd4);
        check("bp_cdb_e4", 64'(CDBData), 64'(bus(1, 4'd3, 16'h0033, 1, 4'd2, 16'h0022)));
        tick();
        check("bp_cdb_e5", 64'(CDBData), 64'(bus(1, 4'd2, 16'h0022, 1, 4'd1, 16'h0011)));
        idle_srcs();
        tick();
        check("bp_drain_occ1", 64'(occupancy), 64'd2);
        tick();
        check("bp_drain_occ2", 64'(occupancy), 64'd0);
        tick();
        check("bp_drain_cdb", 64'(CDBData), 64'd0);

        // Flush with three queued entries and src0 offering a result
        set_all(4'hD, 16'hD00D, 4'hE, 16'hE00E, 4'hF, 16'hF00F);
        tick();
        check("fl_occ_pre", 64'(occupancy), 64'd3);
        idle_srcs();
        flush = 1;
        src0_valid = 1; src0_tag = 4'd7; src0_data = 16'h7777;
        #1;
        check("fl_rdy", 64'({src0_ready, src1_ready, src2_ready}), 64'b000);
        tick();
        flush = 0;
        idle_srcs();
        check("fl_occ", 64'(occupancy), 64'd0);
        check("fl_cdb0", 64'(CDBData), 64'd0);
        tick();
        check("fl_cdb1", 64'(CDBData), 64'd0);
        tick();
        check("fl_cdb2", 64'(CDBData), 64'd0);

        // Ten singles across pointer wrap, alternating src0/src1
        for (int i = 0; i <= 10; i++) begin
            idle_srcs();
            if (i < 10) begin
                if (i % 2 == 0) begin
                    src0_valid = 1; src0_tag = 4'(i); src0_data = 16'h0100 + 16'(i);
                end else begin
                    src1_valid = 1; src1_tag = 4'(i); src1_data = 16'h0100 + 16'(i);
                end
            end
            tick();
            if (i >= 1) begin
                check($sformatf("wrap_cdb%0d", i - 1), 64'(CDBData),
                      64'(bus(0, 0, 0, 1, 4'(i - 1), 16'h0100 + 16'(i - 1))));
            end
        end
        idle_srcs();
        tick();
        check("wrap_cdb_end", 64'(CDBData), 64'd0);

        // Asynchronous reset mid-operation
        set_all(4'd8, 16'h8888, 4'd9, 16'h9999, 4'hA, 16'hAAAA);
        tick();
        check("mr_occ_pre", 64'(occupancy), 64'd3);
        #2;
        rst_n = 0;
        #1;
        check("mr_cdb", 64'(CDBData), 64'd0);
        check("mr_occ", 64'(occupancy), 64'd0);
        check("mr_rdy", 64'({src0_ready, src1_ready, src2_ready}), 64'b000);
        tick();
        check("mr_cdb_held", 64'(CDBData), 64'd0);
        rst_n = 1;
        #1;
        check("mr_rdy_rel", 64'({src0_ready, src1_ready, src2_ready}), 64'b111);
        idle_srcs();
        tick();
        check("mr_cdb_next", 64'(CDBData), 64'd0);
        check("mr_occ_next", 64'(occupancy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
